// File: rtl/ex_mem_pipe_pkg.sv
// Shared core definitions for the EX/MEM pipeline register.
// Widths, branch-op codes, drain FSM states and the MEM entry bundle.
package ex_mem_pipe_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int BR_W   = 3;

   typedef enum logic [BR_W-1:0] {
      BR_NE  = 3'd0,
      BR_EQ  = 3'd1,
      BR_GT  = 3'd2,
      BR_LT  = 3'd3,
      BR_GE  = 3'd4,
      BR_LE  = 3'd5,
      BR_OV  = 3'd6,
      BR_UNC = 3'd7
   } br_op_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } fsm_state_e;

   typedef struct packed {
      logic              valid;
      logic              mem_read;
      logic              mem_write;
      logic              saw_branch;
      logic              reg_write;
      logic              mem_to_reg;
      logic [BR_W-1:0]   branch_op;
      logic [REG_W-1:0]  dst_reg;
      logic [DATA_W-1:0] address;
      logic [DATA_W-1:0] write_data;
   } mem_entry_t;

   localparam mem_entry_t BUBBLE = '0;

   // Increment that sticks at all-ones.
   function automatic logic [DATA_W-1:0] sat_inc(
      input logic [DATA_W-1:0] v
   );
      return (&v) ? v : v + DATA_W'(1);
   endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// EX/MEM boundary bundle: EX results and hazard controls in,
// MEM-stage entry, forwarding source and status out.
interface ex_mem_if;
   import ex_mem_pipe_pkg::*;

   logic              stall;
   logic              flush;
   logic              pcsrc;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_aluResult;
   logic [DATA_W-1:0] ex_writeData;
   logic              ex_memRead;
   logic              ex_memWrite;
   logic              ex_sawBranch;
   logic              ex_regWrite;
   logic              ex_memToReg;
   logic              ex_hlt;
   logic [BR_W-1:0]   ex_branchOp;
   logic [REG_W-1:0]  ex_dstReg;

   logic [DATA_W-1:0] address;
   logic [DATA_W-1:0] writeData;
   logic              memRead;
   logic              memWrite;
   logic              sawBranch;
   logic [BR_W-1:0]   branchOp;
   logic              regWrite;
   logic              memToReg;
   logic [REG_W-1:0]  dstReg;
   logic              valid;
   logic              fwd_en;
   logic [REG_W-1:0]  fwd_reg;
   logic [DATA_W-1:0] fwd_data;
   logic              halted;
   logic [DATA_W-1:0] bubble_cnt;

   modport master (
      output stall, flush, pcsrc, ex_valid,
      output ex_aluResult, ex_writeData,
      output ex_memRead, ex_memWrite, ex_sawBranch,
      output ex_regWrite, ex_memToReg, ex_hlt,
      output ex_branchOp, ex_dstReg,
      input  address, writeData, memRead, memWrite,
      input  sawBranch, branchOp, regWrite, memToReg,
      input  dstReg, valid, fwd_en, fwd_reg, fwd_data,
      input  halted, bubble_cnt
   );

   modport slave (
      input  stall, flush, pcsrc, ex_valid,
      input  ex_aluResult, ex_writeData,
      input  ex_memRead, ex_memWrite, ex_sawBranch,
      input  ex_regWrite, ex_memToReg, ex_hlt,
      input  ex_branchOp, ex_dstReg,
      output address, writeData, memRead, memWrite,
      output sawBranch, branchOp, regWrite, memToReg,
      output dstReg, valid, fwd_en, fwd_reg, fwd_data,
      output halted, bubble_cnt
   );

endinterface

// File: rtl/ex_mem_pipe_halt_drain_fsm.sv
// Halt drain controller: after a halt enters MEM, feeds bubbles
// until the younger stages retire, then parks in HALTED.
module halt_drain_fsm
   import ex_mem_pipe_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic adv_i,
   input  logic start_i,
   output logic force_bubble_o,
   output logic halted_o
);

   localparam int CNT_W =
      (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   fsm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and drain counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: count down drain edges, halt once the count is spent.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (start_i) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYCLES);
            end
         end
         ST_DRAIN: begin
            if (adv_i) begin
               if (cnt_q == '0) begin
                  state_d = ST_HALTED;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   assign force_bubble_o = (state_q == ST_DRAIN);
   assign halted_o       = (state_q == ST_HALTED);

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures EX results for MEM, squashes
// wrong-path entries, inserts/counts bubbles and runs halt drain.
module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   ex_mem_if.slave bus
);

   mem_entry_t        entry_q, entry_d;
   logic [DATA_W-1:0] bcnt_q, bcnt_d;
   logic              count_bubble;
   logic              drain;
   logic              halted;
   logic              run_capture;
   logic              fsm_adv;
   logic              fsm_start;
   mem_entry_t        cap;

   // A flush forces a bubble even during a stall, so it is an advancing edge.
   assign fsm_adv     = bus.flush | ~bus.stall;
   assign run_capture = ~halted & ~drain & ~bus.flush
                      & ~bus.stall & ~bus.pcsrc;
   assign fsm_start   = run_capture & bus.ex_valid & bus.ex_hlt;

   halt_drain_fsm #(
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) u_fsm (
      .clk            (clk),
      .rst            (rst),
      .adv_i          (fsm_adv),
      .start_i        (fsm_start),
      .force_bubble_o (drain),
      .halted_o       (halted)
   );

   // Captured EX entry; control bits of an invalid slot are zeroed.
   always_comb begin
      cap            = BUBBLE;
      cap.valid      = bus.ex_valid;
      cap.mem_read   = bus.ex_valid & bus.ex_memRead;
      cap.mem_write  = bus.ex_valid & bus.ex_memWrite;
      cap.saw_branch = bus.ex_valid & bus.ex_sawBranch;
      cap.reg_write  = bus.ex_valid & bus.ex_regWrite;
      cap.mem_to_reg = bus.ex_valid & bus.ex_memToReg;
      cap.branch_op  = bus.ex_branchOp;
      cap.dst_reg    = bus.ex_dstReg;
      cap.address    = bus.ex_aluResult;
      cap.write_data = bus.ex_writeData;
   end

   // Edge priority: halted > flush > stall > drain > squash > capture.
   always_comb begin
      entry_d      = entry_q;
      count_bubble = 1'b0;
      if (halted) begin
         entry_d = BUBBLE;
      end else if (bus.flush) begin
         entry_d      = BUBBLE;
         count_bubble = 1'b1;
      end else if (bus.stall) begin
         entry_d = entry_q;
      end else if (drain) begin
         entry_d = BUBBLE;
      end else if (bus.pcsrc) begin
         entry_d      = BUBBLE;
         count_bubble = 1'b1;
      end else begin
         entry_d      = cap;
         count_bubble = ~bus.ex_valid;
      end
      bcnt_d = count_bubble ? sat_inc(bcnt_q) : bcnt_q;
   end

   // MEM entry and bubble counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= BUBBLE;
         bcnt_q  <= '0;
      end else begin
         entry_q <= entry_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign bus.address    = entry_q.address;
   assign bus.writeData  = entry_q.write_data;
   assign bus.memRead    = entry_q.mem_read;
   assign bus.memWrite   = entry_q.mem_write;
   assign bus.sawBranch  = entry_q.saw_branch;
   assign bus.branchOp   = entry_q.branch_op;
   assign bus.regWrite   = entry_q.reg_write;
   assign bus.memToReg   = entry_q.mem_to_reg;
   assign bus.dstReg     = entry_q.dst_reg;
   assign bus.valid      = entry_q.valid;
   assign bus.fwd_en     = entry_q.reg_write & ~entry_q.mem_to_reg
                         & entry_q.valid;
   assign bus.fwd_reg    = entry_q.dst_reg;
   assign bus.fwd_data   = entry_q.address;
   assign bus.halted     = halted;
   assign bus.bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Randomized self-checking bench for ex_mem_pipe against a
// behavioural model of the EX/MEM register.
module tb_ex_mem_pipe;

   localparam int DRAIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;

   ex_mem_if bus ();

   ex_mem_pipe #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model of what MEM should see.
   logic        m_valid, m_rd, m_wr, m_br, m_rw, m_m2r;
   logic [15:0] m_addr, m_wd;
   logic [2:0]  m_bop;
   logic [3:0]  m_dst;
   int          m_cnt;
   int          m_drain;
   logic        m_halted;

   function automatic logic [82:0] obs();
      return {bus.valid, bus.memRead, bus.memWrite, bus.sawBranch,
              bus.regWrite, bus.memToReg, bus.address, bus.writeData,
              bus.branchOp, bus.dstReg, bus.fwd_en, bus.fwd_reg,
              bus.fwd_data, bus.halted, bus.bubble_cnt};
   endfunction

   function automatic logic [82:0] expv();
      logic [15:0] c;
      c = 16'(m_cnt);
      return {m_valid, m_rd, m_wr, m_br, m_rw, m_m2r, m_addr, m_wd,
              m_bop, m_dst, m_rw & ~m_m2r & m_valid, m_dst, m_addr,
              m_halted, c};
   endfunction

   task automatic m_bubble();
      {m_valid, m_rd, m_wr, m_br, m_rw, m_m2r} = '0;
      m_addr = '0; m_wd = '0; m_bop = '0; m_dst = '0;
   endtask

   task automatic m_count();
      if (m_cnt < 65535) m_cnt++;
   endtask

   task automatic m_drain_step();
      if (m_drain == 0) begin
         m_halted = 1'b1;
         m_drain  = -1;
      end else begin
         m_drain--;
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_bubble(); m_cnt = 0; m_drain = -1; m_halted = 1'b0;
      end else if (m_halted) begin
         m_bubble();
      end else if (bus.flush) begin
         m_bubble(); m_count();
         if (m_drain >= 0) m_drain_step();
      end else if (bus.stall) begin
      end else if (m_drain >= 0) begin
         m_bubble(); m_drain_step();
      end else if (bus.pcsrc) begin
         m_bubble(); m_count();
      end else begin
         m_valid = bus.ex_valid;
         m_rd  = bus.ex_valid & bus.ex_memRead;
         m_wr  = bus.ex_valid & bus.ex_memWrite;
         m_br  = bus.ex_valid & bus.ex_sawBranch;
         m_rw  = bus.ex_valid & bus.ex_regWrite;
         m_m2r = bus.ex_valid & bus.ex_memToReg;
         m_addr = bus.ex_aluResult; m_wd = bus.ex_writeData;
         m_bop = bus.ex_branchOp; m_dst = bus.ex_dstReg;
         if (!bus.ex_valid) m_count();
         if (bus.ex_valid && bus.ex_hlt) m_drain = DRAIN;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      bus.stall = 0; bus.flush = 0; bus.pcsrc = 0; bus.ex_valid = 0;
      bus.ex_aluResult = 0; bus.ex_writeData = 0;
      bus.ex_memRead = 0; bus.ex_memWrite = 0; bus.ex_sawBranch = 0;
      bus.ex_regWrite = 0; bus.ex_memToReg = 0; bus.ex_hlt = 0;
      bus.ex_branchOp = 0; bus.ex_dstReg = 0;
   endtask

   task automatic rand_ex(input bit valid_only, input bit allow_hlt);
      bus.ex_valid     = valid_only ? 1'b1 : ($urandom_range(3) != 0);
      bus.ex_aluResult = 16'($urandom);
      bus.ex_writeData = 16'($urandom);
      bus.ex_memRead   = 1'($urandom);
      bus.ex_memWrite  = 1'($urandom);
      bus.ex_sawBranch = 1'($urandom);
      bus.ex_regWrite  = 1'($urandom);
      bus.ex_memToReg  = 1'($urandom);
      bus.ex_hlt       = allow_hlt ? 1'($urandom) : 1'b0;
      bus.ex_branchOp  = bus.ex_valid ? 3'($urandom) : 3'd0;
      bus.ex_dstReg    = 4'($urandom);
   endtask

   task automatic do_reset();
      rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1;
      rand_ex(1'b1, 1'b1);
      bus.flush = 1; bus.pcsrc = 1;
      tick(); tick();
      total++;
      if (obs() !== 83'd0)
         $display("FAIL reset: got %h want 0", obs());
      else passed++;
      set_idle();
   endtask

   task automatic test_store();
      set_idle();
      rst = 1;
      bus.ex_valid = 1; bus.ex_aluResult = 16'h1234;
      bus.ex_memWrite = 1; bus.ex_writeData = 16'hBEEF;
      bus.ex_dstReg = 4'd5;
      tick();
      rst = 0;
      tick();
      total++;
      if ({bus.address, bus.memWrite, bus.writeData, bus.valid,
           bus.bubble_cnt} !== {16'h1234, 1'b1, 16'hBEEF, 1'b1, 16'd0})
         $display("FAIL store: got a=%h w=%b d=%h v=%b c=%0d",
                  bus.address, bus.memWrite, bus.writeData, bus.valid,
                  bus.bubble_cnt);
      else passed++;
      total++;
      if (obs() !== expv())
         $display("FAIL store_model: got %h want %h", obs(), expv());
      else passed++;
   endtask

   task automatic test_pcsrc();
      bus.ex_aluResult = 16'h0040; bus.ex_memWrite = 1;
      bus.ex_writeData = 16'h5555; bus.ex_valid = 1;
      bus.pcsrc = 1;
      tick();
      total++;
      if ({bus.memWrite, bus.valid, bus.bubble_cnt} !==
          {1'b0, 1'b0, 16'd1})
         $display("FAIL pcsrc: got w=%b v=%b c=%0d want 0 0 1",
                  bus.memWrite, bus.valid, bus.bubble_cnt);
      else passed++;
      set_idle();
   endtask

   task automatic test_stall();
      logic [82:0] snap;
      set_idle();
      rand_ex(1'b1, 1'b0);
      tick();
      snap = obs();
      bus.stall = 1;
      for (int i = 0; i < 3; i++) begin
         rand_ex(1'b0, 1'b1);
         tick();
         total++;
         if (obs() !== snap)
            $display("FAIL stall_hold%0d: got %h want %h", i, obs(), snap);
         else passed++;
      end
      bus.pcsrc = 1;
      for (int i = 0; i < 2; i++) begin
         rand_ex(1'b1, 1'b1);
         tick();
         total++;
         if (obs() !== snap)
            $display("FAIL stall_pcsrc%0d: got %h want %h", i, obs(), snap);
         else passed++;
      end
      bus.stall = 0;
      tick();
      total++;
      if ({bus.valid, bus.memWrite, bus.bubble_cnt} !==
          {1'b0, 1'b0, snap[15:0] + 16'd1})
         $display("FAIL stall_release: got v=%b c=%0d want 0 %0d",
                  bus.valid, bus.bubble_cnt, snap[15:0] + 16'd1);
      else passed++;
      total++;
      if (obs() !== expv())
         $display("FAIL stall_model: got %h want %h", obs(), expv());
      else passed++;
      set_idle();
   endtask

   task automatic test_flush_stall();
      int c0;
      set_idle();
      rand_ex(1'b1, 1'b0);
      tick();
      c0 = int'(bus.bubble_cnt);
      bus.flush = 1; bus.stall = 1;
      rand_ex(1'b1, 1'b0);
      tick();
      total++;
      if ({bus.valid, bus.regWrite, int'(bus.bubble_cnt)} !==
          {1'b0, 1'b0, c0 + 1})
         $display("FAIL flush_stall: got v=%b c=%0d want 0 %0d",
                  bus.valid, bus.bubble_cnt, c0 + 1);
      else passed++;
      set_idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rand_ex(1'b0, 1'b0);
         bus.flush = ($urandom_range(15) == 0);
         bus.stall = ($urandom_range(7) == 0);
         bus.pcsrc = ($urandom_range(7) == 0);
         tick();
         total++;
         if (obs() !== expv())
            $display("FAIL random%0d: got %h want %h", i, obs(), expv());
         else passed++;
      end
      set_idle();
   endtask

   task automatic test_halt();
      set_idle();
      rand_ex(1'b1, 1'b0);
      bus.ex_hlt = 1;
      tick();
      total++;
      if ({bus.valid, bus.halted} !== 2'b10 || obs() !== expv())
         $display("FAIL hlt_capture: got %h want %h", obs(), expv());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         rand_ex(1'b1, 1'b1);
         bus.stall = (i == 1);
         tick();
         total++;
         if (bus.halted !== (i == 3) || bus.valid !== 1'b0 ||
             obs() !== expv())
            $display("FAIL drain%0d: got h=%b v=%b %h want %h", i,
                     bus.halted, bus.valid, obs(), expv());
         else passed++;
      end
      for (int i = 0; i < 10; i++) begin
         rand_ex(1'b1, 1'b1);
         bus.flush = 1'($urandom); bus.stall = 1'($urandom);
         bus.pcsrc = 1'($urandom);
         tick();
         total++;
         if (bus.halted !== 1'b1 || bus.valid !== 1'b0 ||
             obs() !== expv())
            $display("FAIL halted%0d: got %h want %h", i, obs(), expv());
         else passed++;
      end
      set_idle();
      do_reset();
      total++;
      if (obs() !== 83'd0)
         $display("FAIL halt_reset: got %h want 0", obs());
      else passed++;
      rand_ex(1'b1, 1'b0);
      tick();
      total++;
      if (bus.valid !== 1'b1 || bus.halted !== 1'b0 || obs() !== expv())
         $display("FAIL after_halt: got %h want %h", obs(), expv());
      else passed++;
      set_idle();
   endtask

   task automatic test_reset_mid_drain();
      set_idle();
      rand_ex(1'b1, 1'b0);
      bus.ex_hlt = 1;
      tick();
      set_idle();
      tick();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rand_ex(1'b1, 1'b0);
         tick();
         total++;
         if (bus.halted !== 1'b0 || bus.valid !== 1'b1 ||
             obs() !== expv())
            $display("FAIL mid_drain_reset%0d: got %h want %h", i,
                     obs(), expv());
         else passed++;
      end
      set_idle();
   endtask

   task automatic test_hlt_squash();
      set_idle();
      rand_ex(1'b1, 1'b0);
      bus.ex_hlt = 1; bus.pcsrc = 1;
      tick();
      bus.pcsrc = 0;
      for (int i = 0; i < 6; i++) begin
         rand_ex(1'b0, 1'b0);
         tick();
         total++;
         if (bus.halted !== 1'b0 || obs() !== expv())
            $display("FAIL hlt_squash%0d: got %h want %h", i,
                     obs(), expv());
         else passed++;
      end
      set_idle();
   endtask

   task automatic test_saturation();
      set_idle();
      do_reset();
      for (int i = 0; i < 65534; i++) tick();
      total++;
      if (bus.bubble_cnt !== 16'hFFFE)
         $display("FAIL sat_fffe: got %h want fffe", bus.bubble_cnt);
      else passed++;
      tick(); tick();
      total++;
      if (bus.bubble_cnt !== 16'hFFFF)
         $display("FAIL sat_10000: got %h want ffff", bus.bubble_cnt);
      else passed++;
      bus.flush = 1;
      tick(); tick(); tick();
      total++;
      if (bus.bubble_cnt !== 16'hFFFF || obs() !== expv())
         $display("FAIL sat_hold: got %h want ffff", bus.bubble_cnt);
      else passed++;
      set_idle();
   endtask

   initial begin
      set_idle();
      m_bubble(); m_cnt = 0; m_drain = -1; m_halted = 1'b0;
      test_reset();
      test_store();
      test_pcsrc();
      test_stall();
      test_flush_stall();
      test_random();
      test_halt();
      test_reset_mid_drain();
      test_hlt_squash();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

EX/MEM pipeline register for the 16-bit pipelined core, directly upstream of the MEM stage. Captures EX-stage results each cycle and presents them as MEM's `address`, `writeData`, `memRead`, `memWrite`, `sawBranch` and `branchOp`, plus the write-back controls that travel on to MEM/WB. Squashes the entry behind a taken branch using MEM's `PCSrc`, inserts bubbles on hazard-unit flush, holds on stall, and runs the halt-drain state machine.

## Interface
- `DRAIN_CYCLES`, 2: stages after MEM that must retire before `halted` asserts (MEM, WB).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold all registers.
- `flush` in 1: load a bubble.
- `pcsrc` in 1: MEM's `PCSrc`; the instruction now in EX is wrong-path.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_aluResult` in 16: effective address / ALU result.
- `ex_writeData` in 16: store data.
- `ex_memRead`, `ex_memWrite`, `ex_sawBranch`, `ex_regWrite`, `ex_memToReg`, `ex_hlt` in 1 each: EX control bits.
- `ex_branchOp` in 3: branch condition code.
- `ex_dstReg` in 4: destination register.
- `address`, `writeData` out 16: to MEM.
- `memRead`, `memWrite`, `sawBranch` out 1: to MEM.
- `branchOp` out 3: to MEM.
- `regWrite`, `memToReg` out 1; `dstReg` out 4: to MEM/WB.
- `valid` out 1: MEM-stage entry is real.
- `fwd_en` out 1; `fwd_reg` out 4; `fwd_data` out 16: EX-forwarding source (= `regWrite & ~memToReg & valid`, `dstReg`, `address`).
- `halted` out 1: core halted.
- `bubble_cnt` out 16: bubbles inserted since reset.

## Operation
- Priority each edge: `rst` > HALTED state > `flush` > `stall` > `pcsrc` > normal capture.
- Bubble: `valid`, `memRead`, `memWrite`, `sawBranch`, `regWrite`, `memToReg` = 0; data/`dstReg`/`branchOp` = 0.
- `flush`: load bubble, `bubble_cnt` += 1.
- `stall` (no flush): every register holds, including FSM and counters.
- `pcsrc` (no flush/stall): load bubble, `bubble_cnt` += 1; a squashed `ex_hlt` is ignored.
- Normal: capture all `ex_*`; if `ex_valid`=0, control bits are forced to 0 regardless of inputs and `bubble_cnt` += 1.
- `bubble_cnt` saturates at 0xFFFF.
- FSM states RUN, DRAIN, HALTED.
  - RUN -> DRAIN: normal capture of `ex_valid & ex_hlt`; drain counter loads `DRAIN_CYCLES`.
  - In DRAIN, every non-stalled cycle loads a bubble irrespective of inputs and decrements the drain counter. The drain bubbles are not counted in `bubble_cnt`.
  - DRAIN -> HALTED: when the counter reaches 0.
  - In HALTED: `halted`=1, all control outputs 0, all inputs ignored until `rst`.
- `flush` in DRAIN is permitted; it has no extra effect beyond the bubble.

## Timing
- Latency: one cycle, EX inputs to outputs.
- Outputs are registered only; no combinational input-to-output path.
- Reset values: all outputs 0, FSM = RUN, `bubble_cnt` = 0.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
- `pcsrc` and `stall` asserted together: hold. The branch stays in MEM and `pcsrc` remains high, so the squash applies on the first unstalled edge.
- `halted` rises `DRAIN_CYCLES`+1 unstalled edges after the hlt capture edge.

## Structure
- Shared core package holds:
  - branch-op encoding (3-bit);
  - register-index width (4);
  - data width (16);
  - FSM state encoding.
- One sub-module is natural: `halt_drain_fsm`, which owns the state and drain counter and outputs `force_bubble` and `halted`.

## Test plan
- Reset, then capture `ex_aluResult`=0x1234, `ex_memWrite`=1, `ex_writeData`=0xBEEF, `ex_valid`=1 -> next cycle `address`=0x1234, `memWrite`=1, `writeData`=0xBEEF, `valid`=1.
- `pcsrc`=1 while EX holds a store -> next cycle `memWrite`=0, `valid`=0, `bubble_cnt`=1.
- `stall`=1 for 3 cycles with changing `ex_*` -> outputs unchanged; `stall` with `pcsrc`=1 -> hold, then squash on release.
- `flush`=1 with `stall`=1 -> bubble loaded, `bubble_cnt` increments.
- Capture `ex_hlt` -> 2 unstalled drain cycles, then `halted`=1; inputs ignored afterwards; `rst` clears to RUN.
- `ex_hlt` squashed by `pcsrc` -> `halted` never asserts; 0x10000 bubbles -> `bubble_cnt`=0xFFFF.
